pc_update: RTL and testbench

Owns the program counter and the FETCH/EXEC sequencing for the Harvard core. It produces the `state` signal that clocks `branch_control`, and consumes that block's registered `jump_addr_selection` one instruction later. The jump is therefore applied only after the branch delay slot has executed. It also detects the halt condition (a jump to address 0) and provides the link address for JAL/JALR/BGEZAL/BLTZAL writeback.

---
 rtl/pc_update.sv | 103 ++++++++++
 tb/tb_pc_update.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_update.sv
// rtl/pc_update.sv - program counter, FETCH/EXEC sequencing, delayed-jump targets and halt detection
module pc_update #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instruction_word,
  input  logic [31:0] rs_data,
  input  logic [1:0]  jump_addr_selection,
  output logic [31:0] pc,
  output logic        state,
  output logic [31:0] link_addr,
  output logic        active,
  output logic        addr_error
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_ABS  = 2'b01;
  localparam logic [1:0] SEL_PAGE = 2'b10;
  localparam logic [1:0] SEL_REL  = 2'b11;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        active_q;
  logic        addr_error_q;
  logic [31:0] rel_t_q;
  logic [31:0] page_t_q;
  logic [31:0] abs_t_q;

  logic [31:0] pc_plus4;
  logic [31:0] rel_t_d;
  logic [31:0] page_t_d;
  logic [31:0] next_pc_d;
  logic        misaligned;

  assign pc_plus4 = pc_q + 32'd4;
  assign rel_t_d  = pc_plus4 + {{14{instruction_word[15]}}, instruction_word[15:0], 2'b00};
  assign page_t_d = {pc_plus4[31:28], instruction_word[25:0], 2'b00};

  always_comb begin
    next_pc_d = pc_plus4;
    case (jump_addr_selection)
      SEL_ABS:  next_pc_d = abs_t_q;
      SEL_PAGE: next_pc_d = page_t_d_hold();
      SEL_REL:  next_pc_d = rel_t_q;
      default:  next_pc_d = pc_plus4;
    endcase
  end

  function automatic logic [31:0] page_t_d_hold();
    return page_t_q;
  endfunction

  assign misaligned = (jump_addr_selection == SEL_ABS) && (abs_t_q[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_VECTOR;
      active_q     <= 1'b1;
      addr_error_q <= 1'b0;
      rel_t_q      <= '0;
      page_t_q     <= '0;
      abs_t_q      <= '0;
    end else if (!stall) begin
      case (state_q)
        FETCH: begin
          if (active_q) state_q <= EXEC;
        end
        EXEC: begin
          state_q <= FETCH;
          // A delay-slot EXEC must not clobber the targets its branch captured.
          if (jump_addr_selection == SEL_NONE) begin
            rel_t_q  <= rel_t_d;
            page_t_q <= page_t_d;
            abs_t_q  <= rs_data;
          end
          pc_q <= next_pc_d;
          if (misaligned) begin
            addr_error_q <= 1'b1;
            active_q     <= 1'b0;
          end else if (next_pc_d == 32'h0000_0000) begin
            active_q <= 1'b0;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign pc         = pc_q;
  assign state      = state_q;
  assign link_addr  = pc_plus4 + 32'd4;
  assign active     = active_q;
  assign addr_error = addr_error_q;

endmodule

// File: tb/tb_pc_update.sv
// tb/tb_pc_update.sv - directed self-checking bench for pc_update
module tb_pc_update;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] instruction_word;
  logic [31:0] rs_data;
  logic [1:0]  jump_addr_selection;
  logic [31:0] pc;
  logic        state;
  logic [31:0] link_addr;
  logic        active;
  logic        addr_error;

  int total;
  int bad;

  pc_update #(.RESET_VECTOR(32'hBFC00000)) dut (
    .clk                 (clk),
    .reset               (reset),
    .stall               (stall),
    .instruction_word    (instruction_word),
    .rs_data             (rs_data),
    .jump_addr_selection (jump_addr_selection),
    .pc                  (pc),
    .state               (state),
    .link_addr           (link_addr),
    .active              (active),
    .addr_error          (addr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset               = 1'b1;
    stall               = 1'b0;
    instruction_word    = 32'h0;
    rs_data             = 32'h0;
    jump_addr_selection = 2'b00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset state
    do_reset();
    chk("rst_pc", pc, 32'hBFC00000);
    chk("rst_state", {31'b0, state}, 32'd0);
    chk("rst_active", {31'b0, active}, 32'd1);
    chk("rst_addr_err", {31'b0, addr_error}, 32'd0);
    chk("rst_link", link_addr, 32'hBFC00008);

    // Four NOPs
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("nop%0d_fetch_pc", i), pc, 32'hBFC00000 + 32'(i * 4));
      chk($sformatf("nop%0d_fetch_st", i), {31'b0, state}, 32'd0);
      tick();
      chk($sformatf("nop%0d_exec_st", i), {31'b0, state}, 32'd1);
      chk($sformatf("nop%0d_exec_pc", i), pc, 32'hBFC00000 + 32'(i * 4));
      tick();
    end
    chk("nop_active", {31'b0, active}, 32'd1);

    // Stall in FETCH holds state
    stall = 1'b1;
    tick();
    chk("fstall_state", {31'b0, state}, 32'd0);
    chk("fstall_pc", pc, 32'hBFC00010);
    stall = 1'b0;

    // BEQ imm=3 at BFC00000, taken during delay slot
    do_reset();
    tick();
    instruction_word = 32'h10000003;
    chk("beq_exec_pc", pc, 32'hBFC00000);
    tick();
    chk("beq_slot_pc", pc, 32'hBFC00004);
    tick();
    instruction_word    = 32'h0;
    jump_addr_selection = 2'b11;
    tick();
    jump_addr_selection = 2'b00;
    chk("beq_target_pc", pc, 32'hBFC00010);
    chk("beq_target_st", {31'b0, state}, 32'd0);

    // JR to 0 halts
    do_reset();
    tick();
    rs_data = 32'h0;
    tick();
    tick();
    rs_data             = 32'h12345678;
    jump_addr_selection = 2'b01;
    tick();
    jump_addr_selection = 2'b00;
    chk("jr0_pc", pc, 32'h0);
    chk("jr0_active", {31'b0, active}, 32'd0);
    chk("jr0_state", {31'b0, state}, 32'd0);
    tick();
    tick();
    chk("jr0_frozen_st", {31'b0, state}, 32'd0);
    chk("jr0_frozen_pc", pc, 32'h0);
    chk("jr0_no_err", {31'b0, addr_error}, 32'd0);

    // J at BFC00008 with stall during delay slot
    do_reset();
    tick();
    tick();
    tick();
    tick();
    chk("j_fetch_pc", pc, 32'hBFC00008);
    tick();
    instruction_word = 32'h08000100;
    tick();
    chk("j_slot_pc", pc, 32'hBFC0000C);
    tick();
    jump_addr_selection = 2'b10;
    stall               = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("j_stall%0d_pc", i), pc, 32'hBFC0000C);
      chk($sformatf("j_stall%0d_st", i), {31'b0, state}, 32'd1);
    end
    stall = 1'b0;
    tick();
    jump_addr_selection = 2'b00;
    chk("j_target_pc", pc, 32'hB0000400);
    chk("j_active", {31'b0, active}, 32'd1);

    // JALR to misaligned address
    do_reset();
    tick();
    rs_data = 32'hBFC00102;
    chk("jalr_link", link_addr, 32'hBFC00008);
    tick();
    rs_data = 32'h0;
    tick();
    jump_addr_selection = 2'b01;
    tick();
    jump_addr_selection = 2'b00;
    chk("jalr_addr_err", {31'b0, addr_error}, 32'd1);
    chk("jalr_active", {31'b0, active}, 32'd0);
    chk("jalr_pc", pc, 32'hBFC00102);
    tick();
    chk("jalr_frozen_st", {31'b0, state}, 32'd0);

    // Reset during delay-slot EXEC of taken BNE
    do_reset();
    tick();
    instruction_word = 32'h14000003;
    tick();
    tick();
    instruction_word    = 32'h0;
    jump_addr_selection = 2'b11;
    reset               = 1'b1;
    tick();
    reset               = 1'b0;
    jump_addr_selection = 2'b00;
    chk("bne_rst_pc", pc, 32'hBFC00000);
    chk("bne_rst_st", {31'b0, state}, 32'd0);
    tick();
    tick();
    chk("bne_nojump_pc", pc, 32'hBFC00004);
    tick();
    tick();
    chk("bne_nojump_pc2", pc, 32'hBFC00008);

    // Targets cleared by reset: relative jump right after reset goes to 0
    do_reset();
    tick();
    jump_addr_selection = 2'b11;
    tick();
    jump_addr_selection = 2'b00;
    chk("clr_rel_pc", pc, 32'h0);
    chk("clr_rel_active", {31'b0, active}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
